// File: rtl/wb_pipe_stage_pkg.sv
// Shared types for the MEM->WB pipeline stage: occupancy states and the
// payload record carried from MEM to WB (at the default widths).
package wb_pipe_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // "do" is a reserved word, so the memory-data field is do_val.
  typedef struct packed {
    logic                  wreg;
    logic                  m2reg;
    logic [DEF_REG_AW-1:0] dest_reg;
    logic [DEF_DATA_W-1:0] r;
    logic [DEF_DATA_W-1:0] do_val;
  } payload_t;

endpackage

// File: rtl/wb_payload_reg.sv
// Enable-loaded payload register, cleared by the asynchronous reset and
// otherwise holding its value whenever load is low.
module wb_payload_reg #(
  parameter int W = 72
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Payload storage; holds when not loaded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline register with a two-entry skid buffer, writeback data mux
// and a forwarding tap. in_ready depends only on state, never on out_ready.
module wb_pipe_stage
  import wb_pipe_stage_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 5,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [REG_AW-1:0] mdestReg,
  input  logic [DATA_W-1:0] mr,
  input  logic [DATA_W-1:0] mdo,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [REG_AW-1:0] wdestReg,
  output logic [DATA_W-1:0] wr,
  output logic [DATA_W-1:0] wdo,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dest
);

  // Flat payload so the widths track DATA_W/REG_AW rather than the defaults.
  localparam int PW = 2 + REG_AW + 2 * DATA_W;

  state_t          state;
  state_t          next_state;
  logic            head_load;
  logic            skid_load;
  logic            head_from_skid;
  logic [PW-1:0]   in_payload;
  logic [PW-1:0]   head_d;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   skid_q;

  assign in_payload = {mwreg, mm2reg, mdestReg, mr, mdo};
  assign head_d     = head_from_skid ? skid_q : in_payload;

  // Occupancy state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and load enables; flush overrides every other event.
  always_comb begin
    next_state     = state;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            head_load  = 1'b1;
            next_state = ONE;
          end else begin
            next_state = EMPTY;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            head_load  = 1'b1;
            next_state = ONE;
          end else if (in_valid) begin
            skid_load  = 1'b1;
            next_state = FULL;
          end else if (out_ready) begin
            next_state = EMPTY;
          end else begin
            next_state = ONE;
          end
        end
        FULL: begin
          if (out_ready) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            next_state     = ONE;
          end else begin
            next_state = FULL;
          end
        end
        default: begin
          next_state = EMPTY;
        end
      endcase
    end
  end

  wb_payload_reg #(.W(PW)) u_head (
    .clock (clock),
    .reset (reset),
    .load  (head_load),
    .d     (head_d),
    .q     (head_q)
  );

  wb_payload_reg #(.W(PW)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .d     (in_payload),
    .q     (skid_q)
  );

  assign {wwreg, wm2reg, wdestReg, wr, wdo} = head_q;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign wb_we     = out_valid & wwreg & ((ZERO_SUPPRESS == 0) || (wdestReg != '0));
  assign wb_data   = wm2reg ? wdo : wr;
  assign fwd_valid = wb_we;
  assign fwd_dest  = wdestReg;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Scoreboard bench for wb_pipe_stage: accepted entries are queued when driven
// and compared against the head outputs each cycle.
module tb_wb_pipe_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mwreg = 1'b0;
  logic        mm2reg = 1'b0;
  logic [4:0]  mdestReg = 5'd0;
  logic [31:0] mr = 32'd0;
  logic [31:0] mdo = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        wwreg;
  logic        wm2reg;
  logic [4:0]  wdestReg;
  logic [31:0] wr;
  logic [31:0] wdo;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;

  typedef struct {
    logic        wreg;
    logic        m2reg;
    logic [4:0]  dest;
    logic [31:0] r;
    logic [31:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_pipe_stage #(.DATA_W(32), .REG_AW(5), .ZERO_SUPPRESS(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .mdestReg  (mdestReg),
    .mr        (mr),
    .mdo       (mdo),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wwreg     (wwreg),
    .wm2reg    (wm2reg),
    .wdestReg  (wdestReg),
    .wr        (wr),
    .wdo       (wdo),
    .wb_we     (wb_we),
    .wb_data   (wb_data),
    .fwd_valid (fwd_valid),
    .fwd_dest  (fwd_dest)
  );

  always #5 clock = ~clock;

  function automatic ent_t mk(logic w, logic m, logic [4:0] dst, logic [31:0] r, logic [31:0] d);
    ent_t e;
    e.wreg = w; e.m2reg = m; e.dest = dst; e.r = r; e.d = d;
    return e;
  endfunction

  // Drive one cycle, then update the reference queue for that clock edge.
  task automatic step(input logic v, input logic ordy, input logic fl, input ent_t e);
    logic acc;
    logic fire;
    in_valid = v; out_ready = ordy; flush = fl;
    mwreg = e.wreg; mm2reg = e.m2reg; mdestReg = e.dest; mr = e.r; mdo = e.d;
    acc  = v && (sb.size() < 2);
    fire = ordy && (sb.size() > 0);
    @(posedge clock);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (fire) sb.delete(0);
      if (acc) sb.push_back(e);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_checks++;
    if (out_valid !== 1'b0 || wb_we !== 1'b0 || fwd_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: out_valid=%b wb_we=%b fwd_valid=%b in_ready=%b, want 0 0 0 1",
               out_valid, wb_we, fwd_valid, in_ready);
    end
    n_checks++;
    if (wb_data !== 32'd0 || wr !== 32'd0 || wdo !== 32'd0 || wdestReg !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data: wb_data=%h wr=%h wdo=%h wdest=%0d, want all 0", wb_data, wr, wdo, wdestReg);
    end
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    @(posedge clock);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 5'd3, 32'h10 + i, 32'd0));
      n_checks++;
      if (out_valid !== 1'b1 || wr !== 32'h10 + i || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream[%0d]: out_valid=%b wr=%h in_ready=%b, want 1 %h 1",
                 i, out_valid, wr, in_ready, 32'h10 + i);
      end
    end
    step(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 5'd0, 32'd0, 32'd0));
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_wr [5] = '{32'hA, 32'hA, 32'hA, 32'hB, 32'h0};
    logic        exp_ov [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp_ir [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 5'd1, 32'hA, 32'd0));
    for (int i = 0; i < 5; i++) begin
      if (i == 1) step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 5'd1, 32'hB, 32'd0));
      if (i == 2) step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 5'd1, 32'hC, 32'd0));
      if (i >= 3) step(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 5'd0, 32'd0, 32'd0));
      n_checks++;
      if (out_valid !== exp_ov[i] || in_ready !== exp_ir[i] || (exp_ov[i] && wr !== exp_wr[i])) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: out_valid=%b in_ready=%b wr=%h, want %b %b %h",
                 i, out_valid, in_ready, wr, exp_ov[i], exp_ir[i], exp_wr[i]);
      end
    end
  endtask

  task automatic test_wb_mux();
    step(1'b1, 1'b1, 1'b0, mk(1'b1, 1'b1, 5'd7, 32'h1, 32'hDEADBEEF));
    n_checks++;
    if (wb_data !== 32'hDEADBEEF || wdo !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wb_mux_mem: wb_data=%h wdo=%h, want deadbeef", wb_data, wdo);
    end
    step(1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 5'd7, 32'h1, 32'hDEADBEEF));
    n_checks++;
    if (wb_data !== 32'h1) begin
      n_fail++;
      $display("FAIL wb_mux_alu: wb_data=%h, want 00000001", wb_data);
    end
    step(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 5'd0, 32'd0, 32'd0));
  endtask

  task automatic test_zero_reg();
    step(1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 5'd0, 32'h5, 32'd0));
    n_checks++;
    if (out_valid !== 1'b1 || wb_we !== 1'b0 || fwd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg: out_valid=%b wb_we=%b fwd_valid=%b, want 1 0 0", out_valid, wb_we, fwd_valid);
    end
    step(1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 5'd5, 32'h6, 32'd0));
    n_checks++;
    if (wb_we !== 1'b1 || fwd_valid !== 1'b1 || fwd_dest !== 5'd5) begin
      n_fail++;
      $display("FAIL reg5: wb_we=%b fwd_valid=%b fwd_dest=%0d, want 1 1 5", wb_we, fwd_valid, fwd_dest);
    end
    step(1'b1, 1'b1, 1'b0, mk(1'b0, 1'b0, 5'd5, 32'h7, 32'd0));
    n_checks++;
    if (wb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL no_wreg: wb_we=%b, want 0", wb_we);
    end
    step(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 5'd0, 32'd0, 32'd0));
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 5'd2, 32'h21, 32'd0));
    step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 5'd2, 32'h22, 32'd0));
    step(1'b1, 1'b0, 1'b1, mk(1'b1, 1'b0, 5'd2, 32'h23, 32'd0));
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 5'd0, 32'd0, 32'd0));
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_residue[%0d]: out_valid=%b wr=%h, want 0", i, out_valid, wr);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 5'd4, 32'h31, 32'h99));
    step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 5'd4, 32'h32, 32'h98));
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || wr !== 32'd0 || in_ready !== 1'b1 || wb_data !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: out_valid=%b wr=%h in_ready=%b wb_data=%h, want 0 0 1 0",
               out_valid, wr, in_ready, wb_data);
    end
    #1;
    reset = 1'b0;
    sb.delete();
    step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 5'd4, 32'h77, 32'd0));
    n_checks++;
    if (out_valid !== 1'b1 || wr !== 32'h77) begin
      n_fail++;
      $display("FAIL post_reset_first: out_valid=%b wr=%h, want 1 77", out_valid, wr);
    end
    step(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 5'd0, 32'd0, 32'd0));
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    ent_t        e;
    logic        exp_we;
    logic [31:0] exp_data;
    for (int i = 0; i < 300; i++) begin
      e = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             $urandom, $urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0), e);
      n_checks++;
      if (out_valid !== (sb.size() > 0) || in_ready !== (sb.size() < 2)) begin
        n_fail++;
        $display("FAIL b2b_ctrl[%0d]: out_valid=%b in_ready=%b, want occupancy %0d", i, out_valid, in_ready, sb.size());
      end else if (sb.size() > 0) begin
        exp_we   = sb[0].wreg && (sb[0].dest != 5'd0);
        exp_data = sb[0].m2reg ? sb[0].d : sb[0].r;
        n_checks++;
        if (wr !== sb[0].r || wb_data !== exp_data || wb_we !== exp_we || fwd_dest !== sb[0].dest) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: wr=%h wb_data=%h wb_we=%b dest=%0d, want %h %h %b %0d",
                   i, wr, wb_data, wb_we, fwd_dest, sb[0].r, exp_data, exp_we, sb[0].dest);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wb_mux();
    test_zero_reg();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
